uart_cmd_bridge: RTL and testbench

UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

---
 rtl/uart_cmd_bridge.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_bridge.sv
`timescale 1ns/1ps
// uart_cmd_bridge: decodes UART command packets, queues WRITE payload bytes
// for a downstream consumer, captures serial channel data into bytes and
// sends capture/status bytes back through a paced transmit queue.
module uart_cmd_bridge #(
  parameter int DEPTH       = 16,
  parameter int N_CH        = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                    clk_100,
  input  logic                    Reset,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_ready,
  output logic [7:0]              tx_byte,
  output logic                    tx_en,
  input  logic                    tx_busy,
  output logic [7:0]              cmd_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  input  logic [N_CH-1:0]         data_in,
  input  logic                    data_strobe,
  output logic                    busy,
  output logic                    err,
  output logic [$clog2(DEPTH):0]  cmd_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    PAYLOAD,
    GET_N,
    CAPTURE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    len_cnt, len_nxt;
  logic [7:0]    n_cnt, n_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [3:0]    ch, ch_nxt;
  logic [TW-1:0] to_cnt, to_nxt;

  logic          cmd_push, tx_push, flush, status_op, err_set;
  logic [7:0]    tx_wdata;
  logic          waiting, to_expire;
  logic [N_CH-1:0] ch_sel;
  logic          cap_bit;
  logic [7:0]    status_byte;

  // Command queue (first-word-fall-through)
  logic [7:0]    cmd_mem [DEPTH];
  logic [AW-1:0] cmd_wp, cmd_rp;
  logic [AW:0]   cmd_cnt;
  logic          cmd_full, cmd_empty, cmd_wr, cmd_rd;

  // Transmit queue
  logic [7:0]    txq_mem [DEPTH];
  logic [AW-1:0] txq_wp, txq_rp;
  logic [AW:0]   txq_cnt;
  logic          txq_full, txq_empty, txq_wr, tx_send;
  logic          tx_en_d1;

  assign cmd_full  = (cmd_cnt == FULL_CNT);
  assign cmd_empty = (cmd_cnt == '0);
  assign cmd_valid = ~cmd_empty;
  assign cmd_data  = cmd_empty ? 8'h00 : cmd_mem[cmd_rp];
  assign cmd_level = cmd_cnt;
  assign cmd_wr    = cmd_push & ~cmd_full;
  // A flush discards the whole queue, so a concurrent pop has nothing to take.
  assign cmd_rd    = cmd_valid & cmd_ready & ~flush;

  assign txq_full  = (txq_cnt == FULL_CNT);
  assign txq_empty = (txq_cnt == '0);
  assign txq_wr    = tx_push & ~txq_full;
  // Leave two quiet cycles after each pulse so the transmitter can raise busy.
  assign tx_send   = ~txq_empty & ~tx_busy & ~tx_en & ~tx_en_d1;

  assign busy        = (state != IDLE);
  assign ch_sel      = data_in >> ch;
  assign cap_bit     = ch_sel[0];
  assign status_byte = {err, cmd_full, cmd_empty, txq_empty, 4'b0000};
  assign waiting     = (state == GET_LEN) || (state == PAYLOAD) || (state == GET_N);
  assign to_expire   = waiting && !rx_ready && (to_cnt == TO_LAST);

  // State register
  always_ff @(posedge clk_100) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Packet decode: next state, counter updates and queue requests
  always_comb begin
    state_nxt = state;
    len_nxt   = len_cnt;
    n_nxt     = n_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    ch_nxt    = ch;
    to_nxt    = (waiting && !rx_ready) ? to_cnt + 1'b1 : '0;
    cmd_push  = 1'b0;
    tx_push   = 1'b0;
    tx_wdata  = shreg;
    flush     = 1'b0;
    status_op = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_ready) begin
          if (rx_byte == 8'h01) begin
            state_nxt = GET_LEN;
          end else if (rx_byte[7:4] == 4'h1 && int'(rx_byte[3:0]) < N_CH) begin
            ch_nxt    = rx_byte[3:0];
            state_nxt = GET_N;
          end else if (rx_byte == 8'h20) begin
            status_op = 1'b1;
            tx_push   = 1'b1;
            tx_wdata  = status_byte;
          end else if (rx_byte == 8'h30) begin
            flush = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      GET_LEN: begin
        if (rx_ready) begin
          if (rx_byte == 8'h00) begin
            state_nxt = IDLE;
          end else begin
            len_nxt   = rx_byte;
            state_nxt = PAYLOAD;
          end
        end else if (to_expire) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end
      end
      PAYLOAD: begin
        if (rx_ready) begin
          cmd_push = 1'b1;
          len_nxt  = len_cnt - 8'd1;
          if (len_cnt == 8'd1) state_nxt = IDLE;
        end else if (to_expire) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end
      end
      GET_N: begin
        if (rx_ready) begin
          if (rx_byte == 8'h00) begin
            state_nxt = IDLE;
          end else begin
            n_nxt     = rx_byte;
            bit_nxt   = 3'd0;
            state_nxt = CAPTURE;
          end
        end else if (to_expire) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end
      end
      CAPTURE: begin
        if (rx_ready) err_set = 1'b1;
        if (data_strobe) begin
          shreg_nxt = {shreg[6:0], cap_bit};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            tx_push  = 1'b1;
            tx_wdata = {shreg[6:0], cap_bit};
            n_nxt    = n_cnt - 8'd1;
            if (n_cnt == 8'd1) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Packet counters, capture shift register and sticky error flag
  always_ff @(posedge clk_100) begin
    if (Reset) begin
      len_cnt <= '0;
      n_cnt   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ch      <= '0;
      to_cnt  <= '0;
      err     <= 1'b0;
    end else begin
      len_cnt <= len_nxt;
      n_cnt   <= n_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      ch      <= ch_nxt;
      to_cnt  <= to_nxt;
      // STATUS clears the flag, but any error raised in that cycle wins.
      err     <= (status_op ? 1'b0 : err) | err_set | (cmd_push & cmd_full)
                 | (tx_push & txq_full);
    end
  end

  // Command queue pointers and occupancy
  always_ff @(posedge clk_100) begin
    if (Reset) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
    end else if (flush) begin
      cmd_rp  <= cmd_wp;
      cmd_cnt <= '0;
    end else begin
      if (cmd_wr) cmd_wp <= cmd_wp + 1'b1;
      if (cmd_rd) cmd_rp <= cmd_rp + 1'b1;
      cmd_cnt <= cmd_cnt + (AW+1)'(cmd_wr) - (AW+1)'(cmd_rd);
    end
  end

  // Command queue storage
  always_ff @(posedge clk_100) begin
    if (cmd_wr) cmd_mem[cmd_wp] <= rx_byte;
  end

  // Transmit queue pointers and occupancy
  always_ff @(posedge clk_100) begin
    if (Reset) begin
      txq_wp  <= '0;
      txq_rp  <= '0;
      txq_cnt <= '0;
    end else begin
      if (txq_wr)  txq_wp <= txq_wp + 1'b1;
      if (tx_send) txq_rp <= txq_rp + 1'b1;
      txq_cnt <= txq_cnt + (AW+1)'(txq_wr) - (AW+1)'(tx_send);
    end
  end

  // Transmit queue storage
  always_ff @(posedge clk_100) begin
    if (txq_wr) txq_mem[txq_wp] <= tx_wdata;
  end

  // Transmit pacing: one-cycle start pulse with the byte presented alongside
  always_ff @(posedge clk_100) begin
    if (Reset) begin
      tx_en    <= 1'b0;
      tx_en_d1 <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      tx_en    <= tx_send;
      tx_en_d1 <= tx_en;
      if (tx_send) tx_byte <= txq_mem[txq_rp];
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
`timescale 1ns/1ps
// Directed testbench for uart_cmd_bridge with a simple transmitter model
// and a consumer that records every accepted command byte.
module tb_uart_cmd_bridge;

  logic       clk_100 = 1'b0;
  logic       Reset;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic [7:0] tx_byte;
  logic       tx_en;
  logic       tx_busy;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] data_in;
  logic       data_strobe;
  logic       busy;
  logic       err;
  logic [4:0] cmd_level;

  int errors = 0;
  int checks = 0;

  logic [7:0] tx_q[$];
  logic       busy_q[$];
  logic [7:0] cmd_q[$];
  int         busy_left = 0;

  uart_cmd_bridge #(.DEPTH(16), .N_CH(2), .TIMEOUT_CYC(100)) dut (
    .clk_100(clk_100), .Reset(Reset), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .tx_byte(tx_byte), .tx_en(tx_en), .tx_busy(tx_busy),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_in(data_in), .data_strobe(data_strobe), .busy(busy), .err(err),
    .cmd_level(cmd_level)
  );

  always #5 clk_100 = ~clk_100;

  // Transmitter model and consumer recorder, sampled mid-cycle
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk_100);
      #1;
      if (cmd_valid && cmd_ready) cmd_q.push_back(cmd_data);
      if (tx_en) begin
        tx_q.push_back(tx_byte);
        busy_q.push_back(tx_busy);
        tx_busy   = 1'b1;
        busy_left = 6;
      end else if (busy_left > 0) begin
        busy_left = busy_left - 1;
        if (busy_left == 0) tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_100);
    rx_byte  = b;
    rx_ready = 1'b1;
    @(negedge clk_100);
    rx_ready = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_100);
  endtask

  task automatic apply_reset();
    @(negedge clk_100);
    Reset = 1'b1;
    @(negedge clk_100);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    wait_cycles(3);
    checks++; if (tx_en !== 1'b0)      begin errors++; $display("FAIL reset_tx_en got=%b exp=0", tx_en); end
    checks++; if (tx_byte !== 8'h00)   begin errors++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
    checks++; if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
    checks++; if (cmd_data !== 8'h00)  begin errors++; $display("FAIL reset_cmd_data got=%h exp=00", cmd_data); end
    checks++; if (cmd_level !== 5'd0)  begin errors++; $display("FAIL reset_cmd_level got=%0d exp=0", cmd_level); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    Reset = 1'b0;
    @(negedge clk_100);
  endtask

  task automatic test_write_drain();
    int base;
    base = cmd_q.size();
    cmd_ready = 1'b1;
    send_byte(8'h01);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got=%b exp=1", busy); end
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    wait_cycles(4);
    checks++; if (cmd_q.size() !== base + 3) begin errors++; $display("FAIL write_count got=%0d exp=%0d", cmd_q.size() - base, 3); end
    if (cmd_q.size() >= base + 3) begin
      checks++; if (cmd_q[base]   !== 8'hAA) begin errors++; $display("FAIL write_b0 got=%h exp=AA", cmd_q[base]); end
      checks++; if (cmd_q[base+1] !== 8'hBB) begin errors++; $display("FAIL write_b1 got=%h exp=BB", cmd_q[base+1]); end
      checks++; if (cmd_q[base+2] !== 8'hCC) begin errors++; $display("FAIL write_b2 got=%h exp=CC", cmd_q[base+2]); end
    end
    checks++; if (cmd_level !== 5'd0) begin errors++; $display("FAIL write_level got=%0d exp=0", cmd_level); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL write_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL write_idle got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    int base;
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h66; seq[3] = 8'h77;
    base = cmd_q.size();
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_100);
      rx_byte  = seq[i];
      rx_ready = 1'b1;
    end
    @(negedge clk_100);
    rx_ready = 1'b0;
    wait_cycles(4);
    checks++; if (cmd_q.size() !== base + 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", cmd_q.size() - base); end
    if (cmd_q.size() >= base + 2) begin
      checks++; if (cmd_q[base]   !== 8'h66) begin errors++; $display("FAIL b2b_b0 got=%h exp=66", cmd_q[base]); end
      checks++; if (cmd_q[base+1] !== 8'h77) begin errors++; $display("FAIL b2b_b1 got=%h exp=77", cmd_q[base+1]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_overflow();
    int base;
    cmd_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h14);
    for (int i = 0; i < 20; i++) send_byte(8'h40 + 8'(i));
    checks++; if (cmd_level !== 5'd16) begin errors++; $display("FAIL ovf_level got=%0d exp=16", cmd_level); end
    checks++; if (err !== 1'b1)        begin errors++; $display("FAIL ovf_err got=%b exp=1", err); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL ovf_idle got=%b exp=0", busy); end
    checks++; if (cmd_data !== 8'h40)  begin errors++; $display("FAIL ovf_head got=%h exp=40", cmd_data); end
    base = cmd_q.size();
    @(negedge clk_100);
    cmd_ready = 1'b1;
    wait_cycles(20);
    checks++; if (cmd_q.size() !== base + 16) begin errors++; $display("FAIL ovf_drain_count got=%0d exp=16", cmd_q.size() - base); end
    for (int i = 0; i < 16; i++) begin
      if (cmd_q.size() > base + i) begin
        checks++;
        if (cmd_q[base+i] !== 8'h40 + 8'(i)) begin
          errors++; $display("FAIL ovf_drain_b%0d got=%h exp=%h", i, cmd_q[base+i], 8'h40 + 8'(i));
        end
      end
    end
    checks++; if (cmd_level !== 5'd0) begin errors++; $display("FAIL ovf_drained_level got=%0d exp=0", cmd_level); end
  endtask

  task automatic test_status();
    int t0;
    cmd_ready = 1'b1;
    send_byte(8'h7F);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL status_bad_op_err got=%b exp=1", err); end
    t0 = tx_q.size();
    send_byte(8'h20);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL status_err_clear got=%b exp=0", err); end
    for (int i = 0; i < 50 && tx_q.size() < t0 + 1; i++) @(negedge clk_100);
    checks++;
    if (tx_q.size() < t0 + 1) begin errors++; $display("FAIL status_tx_timeout got=%0d exp=1 bytes", tx_q.size() - t0); end
    else if (tx_q[t0] !== 8'hB0) begin errors++; $display("FAIL status_byte got=%h exp=B0", tx_q[t0]); end
    // Status with a byte waiting in the command queue and no error pending.
    cmd_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h77);
    t0 = tx_q.size();
    send_byte(8'h20);
    for (int i = 0; i < 50 && tx_q.size() < t0 + 1; i++) @(negedge clk_100);
    checks++;
    if (tx_q.size() < t0 + 1) begin errors++; $display("FAIL status2_tx_timeout got=%0d exp=1 bytes", tx_q.size() - t0); end
    else if (tx_q[t0] !== 8'h10) begin errors++; $display("FAIL status2_byte got=%h exp=10", tx_q[t0]); end
    checks++; if (cmd_level !== 5'd1) begin errors++; $display("FAIL preflush_level got=%0d exp=1", cmd_level); end
    send_byte(8'h30);
    checks++; if (cmd_level !== 5'd0)  begin errors++; $display("FAIL flush_level got=%0d exp=0", cmd_level); end
    checks++; if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL flush_valid got=%b exp=0", cmd_valid); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL flush_err got=%b exp=0", err); end
  endtask

  task automatic test_capture();
    logic [15:0] pattern;
    logic        b;
    int t0;
    pattern = 16'hA53C;
    apply_reset();
    t0 = tx_q.size();
    send_byte(8'h11);
    send_byte(8'h02);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL capture_busy got=%b exp=1", busy); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_100);
      b = pattern[15-i];
      data_in     = {b, ~b};
      data_strobe = 1'b1;
      rx_ready    = (i == 4);
      rx_byte     = 8'h20;
      @(negedge clk_100);
      data_strobe = 1'b0;
      rx_ready    = 1'b0;
    end
    for (int i = 0; i < 200 && tx_q.size() < t0 + 2; i++) @(negedge clk_100);
    wait_cycles(10);
    checks++; if (tx_q.size() !== t0 + 2) begin errors++; $display("FAIL capture_count got=%0d exp=2", tx_q.size() - t0); end
    if (tx_q.size() >= t0 + 2) begin
      checks++; if (tx_q[t0]   !== 8'hA5) begin errors++; $display("FAIL capture_b0 got=%h exp=A5", tx_q[t0]); end
      checks++; if (tx_q[t0+1] !== 8'h3C) begin errors++; $display("FAIL capture_b1 got=%h exp=3C", tx_q[t0+1]); end
      checks++; if (busy_q[t0]   !== 1'b0) begin errors++; $display("FAIL capture_p0_txbusy got=%b exp=0", busy_q[t0]); end
      checks++; if (busy_q[t0+1] !== 1'b0) begin errors++; $display("FAIL capture_p1_txbusy got=%b exp=0", busy_q[t0+1]); end
    end
    checks++; if (err !== 1'b1)  begin errors++; $display("FAIL capture_rx_err got=%b exp=1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL capture_idle got=%b exp=0", busy); end
    // Channel 2 does not exist with two channels: opcode rejected.
    apply_reset();
    send_byte(8'h12);
    checks++; if (err !== 1'b1)  begin errors++; $display("FAIL bad_ch_err got=%b exp=1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_ch_idle got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    apply_reset();
    cmd_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'hAA);
    wait_cycles(95);
    checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL timeout_early_busy got=%b exp=1", busy); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL timeout_early_err got=%b exp=0", err); end
    wait_cycles(10);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    checks++; if (err !== 1'b1)        begin errors++; $display("FAIL timeout_err got=%b exp=1", err); end
    checks++; if (cmd_level !== 5'd1)  begin errors++; $display("FAIL timeout_level got=%0d exp=1", cmd_level); end
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset();
    cmd_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    checks++; if (cmd_level !== 5'd3) begin errors++; $display("FAIL mid_level_before got=%0d exp=3", cmd_level); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    apply_reset();
    checks++; if (cmd_level !== 5'd0) begin errors++; $display("FAIL mid_level_after got=%0d exp=0", cmd_level); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy_after got=%b exp=0", busy); end
    checks++; if (tx_en !== 1'b0)     begin errors++; $display("FAIL mid_tx_en got=%b exp=0", tx_en); end
    base = cmd_q.size();
    cmd_ready = 1'b1;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h55);
    wait_cycles(4);
    checks++;
    if (cmd_q.size() !== base + 1) begin errors++; $display("FAIL mid_new_count got=%0d exp=1", cmd_q.size() - base); end
    else if (cmd_q[base] !== 8'h55) begin errors++; $display("FAIL mid_new_byte got=%h exp=55", cmd_q[base]); end
  endtask

  initial begin
    Reset       = 1'b1;
    rx_byte     = 8'h00;
    rx_ready    = 1'b0;
    cmd_ready   = 1'b0;
    data_in     = 2'b00;
    data_strobe = 1'b0;
    test_reset();
    test_write_drain();
    test_back_to_back();
    test_overflow();
    test_status();
    test_capture();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
